// File: rtl/mod_ref_gen_pkg.sv
// Shared definitions for the sinusoidal modulation-reference generator.
// Holds the width constants, the sine quadrant type, the signed sample
// type, and small helpers that decode quadrant symmetry.
package mod_ref_gen_pkg;

  localparam int PHASE_W = 32;
  localparam int LUT_AW  = 8;
  localparam int CMP_W   = 16;
  // LUT entries are unsigned magnitudes one bit narrower than a sample.
  localparam int LUT_DW  = CMP_W - 1;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quadrant_e;

  typedef logic signed [CMP_W-1:0] sample_t;

  // Second and fourth quadrants read the quarter wave backwards.
  function automatic logic isMirrored(input quadrant_e q);
    return (q == Q1) || (q == Q3);
  endfunction

  // Lower half of the period is the negative lobe.
  function automatic logic isNegative(input quadrant_e q);
    return (q == Q2) || (q == Q3);
  endfunction

endpackage

// File: rtl/mod_ref_gen_lut.sv
// Quarter-wave sine ROM with a registered address.
// Entry i holds round(32767 * sin((i + 0.5) * pi / 512)) for the default
// 256-entry table; the half-step offset keeps every entry non-zero and makes
// the table symmetric under index inversion.
// Ports:
//   MClk  in   clock; the address register captures on the rising edge
//   Addr  in   quarter-wave index
//   Data  out  unsigned magnitude for the registered address
module sine_quarter_lut
  import mod_ref_gen_pkg::*;
#(
  parameter int AW = LUT_AW
) (
  input  logic              MClk,
  input  logic [AW-1:0]     Addr,
  output logic [LUT_DW-1:0] Data
);

  localparam int  DEPTH = 1 << AW;
  localparam real PI    = 3.14159265358979323846;
  // Angular spacing of half a table step: pi / 2^(AW+2).
  localparam real STEP  = PI * (0.5 ** (AW + 2));
  localparam real AMP   = real'((1 << LUT_DW) - 1);

  logic [LUT_DW-1:0] rom [DEPTH];
  logic [AW-1:0]     addrQ;

  // Table contents are fixed at elaboration; each entry is a constant.
  for (genvar i = 0; i < DEPTH; i++) begin : gRom
    localparam int VAL = $rtoi(AMP * $sin(real'(2 * i + 1) * STEP) + 0.5);
    assign rom[i] = LUT_DW'(VAL);
  end

  always_ff @(posedge MClk) begin
    addrQ <= Addr;
  end

  assign Data = rom[addrQ];

endmodule

// File: rtl/mod_ref_gen.sv
// Sinusoidal modulation-reference generator feeding the PWM level stages.
// A phase accumulator advances by FreqWord on every carrier-period strobe;
// the pre-increment phase is looked up in a quarter-wave sine table, scaled
// by ModIndex and centred in 0..PWMMaxCount.
// Ports:
//   MClk          in   clock, rising edge
//   RstN          in   synchronous active-low reset
//   Enable        in   1 = run; 0 = phase restarts at 0 and output is midpoint
//   UpdateStrobe  in   one-cycle sample request per carrier period
//   FreqWord      in   phase increment, sampled on strobe
//   ModIndex      in   unsigned Q0.16 amplitude, sampled on strobe
//   PWMMaxCount   in   carrier full scale, read live at the output stage
//   Compare       out  registered reference word
//   CompareValid  out  one-cycle pulse per accepted strobe, 3 cycles later
module mod_ref_gen #(
  parameter int PHASE_W = mod_ref_gen_pkg::PHASE_W,
  parameter int LUT_AW  = mod_ref_gen_pkg::LUT_AW
) (
  input  logic               MClk,
  input  logic               RstN,
  input  logic               Enable,
  input  logic               UpdateStrobe,
  input  logic [PHASE_W-1:0] FreqWord,
  input  logic [15:0]        ModIndex,
  input  logic [15:0]        PWMMaxCount,
  output logic [15:0]        Compare,
  output logic               CompareValid
);

  import mod_ref_gen_pkg::*;

  // Quadrant bits plus table index taken from the top of the phase.
  localparam int HI_W = 2 + LUT_AW;

  // (s * {0,m}) >>> 16 with floor semantics from the arithmetic shift.
  function automatic sample_t scaleByIndex(input sample_t s, input logic [15:0] m);
    logic signed [32:0] sW;
    logic signed [32:0] mW;
    logic signed [32:0] prod;
    sW   = 33'(s);
    mW   = {17'b0, m};
    prod = sW * mW;
    return sample_t'(prod >>> 16);
  endfunction

  // H + ((a * H) >>> 15), clamped to [0, maxCount] as a safety net.
  function automatic logic [15:0] centreAndClamp(input sample_t a, input logic [15:0] maxCount);
    logic signed [33:0] aW;
    logic signed [33:0] hW;
    logic signed [33:0] mW;
    logic signed [33:0] prod;
    logic signed [33:0] c;
    aW   = 34'(a);
    hW   = {19'b0, maxCount[15:1]};
    mW   = {18'b0, maxCount};
    prod = aW * hW;
    c    = hW + (prod >>> 15);
    if (c[33]) begin
      return 16'd0;
    end else if (c > mW) begin
      return maxCount;
    end else begin
      return c[15:0];
    end
  endfunction

  logic [PHASE_W-1:0] phaseAcc;

  // ---- stage 0: accumulate phase, capture the pre-increment sample ----
  logic              vld_p0;
  logic              en_p0;
  logic [HI_W-1:0]   phaseHi_p0;
  logic [15:0]       modIdx_p0;

  always_ff @(posedge MClk) begin
    if (!RstN) begin
      phaseAcc <= '0;
      vld_p0   <= 1'b0;
    end else begin
      vld_p0 <= UpdateStrobe;
      if (UpdateStrobe) begin
        phaseAcc <= Enable ? (phaseAcc + FreqWord) : '0;
      end
    end
  end

  always_ff @(posedge MClk) begin
    en_p0      <= Enable;
    phaseHi_p0 <= phaseAcc[PHASE_W-1 -: HI_W];
    modIdx_p0  <= ModIndex;
  end

  // ---- stage 1: quarter-wave lookup (address register inside the ROM) ----
  quadrant_e         quad_p0;
  logic [LUT_AW-1:0] lutAddr;
  logic [LUT_DW-1:0] lutData_p1;
  logic              vld_p1;
  logic              en_p1;
  quadrant_e         quad_p1;
  logic [15:0]       modIdx_p1;

  assign quad_p0 = quadrant_e'(phaseHi_p0[HI_W-1 -: 2]);
  assign lutAddr = isMirrored(quad_p0) ? ~phaseHi_p0[LUT_AW-1:0] : phaseHi_p0[LUT_AW-1:0];

  sine_quarter_lut #(
    .AW(LUT_AW)
  ) uLut (
    .MClk(MClk),
    .Addr(lutAddr),
    .Data(lutData_p1)
  );

  always_ff @(posedge MClk) begin
    if (!RstN) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
    end
  end

  always_ff @(posedge MClk) begin
    en_p1     <= en_p0;
    quad_p1   <= quad_p0;
    modIdx_p1 <= modIdx_p0;
  end

  // ---- stage 2: apply sign and scale by the modulation index ----
  sample_t lutMag_p1;
  sample_t sine_p1;
  logic    vld_p2;
  logic    en_p2;
  sample_t amp_p2;

  assign lutMag_p1 = sample_t'({1'b0, lutData_p1});
  assign sine_p1   = isNegative(quad_p1) ? -lutMag_p1 : lutMag_p1;

  always_ff @(posedge MClk) begin
    if (!RstN) begin
      vld_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge MClk) begin
    en_p2  <= en_p1;
    amp_p2 <= scaleByIndex(sine_p1, modIdx_p1);
  end

  // ---- stage 3: centre into the carrier range and register the output ----
  logic [15:0] halfCount;

  assign halfCount = {1'b0, PWMMaxCount[15:1]};

  always_ff @(posedge MClk) begin
    if (!RstN) begin
      Compare      <= '0;
      CompareValid <= 1'b0;
    end else begin
      CompareValid <= vld_p2;
      if (vld_p2) begin
        Compare <= en_p2 ? centreAndClamp(amp_p2, PWMMaxCount) : halfCount;
      end
    end
  end

endmodule

// File: tb/tb_mod_ref_gen.sv
module tb_mod_ref_gen;

  logic        MClk;
  logic        RstN;
  logic        Enable;
  logic        UpdateStrobe;
  logic [31:0] FreqWord;
  logic [15:0] ModIndex;
  logic [15:0] PWMMaxCount;
  logic [15:0] Compare;
  logic        CompareValid;

  mod_ref_gen dut (
    .MClk(MClk),
    .RstN(RstN),
    .Enable(Enable),
    .UpdateStrobe(UpdateStrobe),
    .FreqWord(FreqWord),
    .ModIndex(ModIndex),
    .PWMMaxCount(PWMMaxCount),
    .Compare(Compare),
    .CompareValid(CompareValid)
  );

  initial MClk = 1'b0;
  always #5 MClk = ~MClk;

  int tests;
  int fails;

  // Behavioural model: pending samples with edges left until they emerge.
  typedef struct {
    bit        en;
    bit [31:0] ph;
    int        mi;
    int        left;
  } pend_t;

  pend_t     pend[$];
  bit [31:0] mPhase;
  int        expCompare;
  bit        expValid;

  int drvEdge;
  int edgeNo;
  int firstValidEdge;
  int seen[$];
  int seenEdges[$];
  int expList[$];

  function automatic longint floorDiv(input longint n, input longint d);
    longint q;
    q = n / d;
    if ((n % d != 0) && (n < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int lutRef(input int i);
    real ang;
    ang = (real'(i) + 0.5) * 3.14159265358979323846 / 512.0;
    return $rtoi(32767.0 * $sin(ang) + 0.5);
  endfunction

  function automatic int refCompare(input bit en, input bit [31:0] ph, input int mi, input int pm);
    longint h;
    longint mag;
    longint s;
    longint a;
    longint c;
    int q;
    int idx;
    h = pm / 2;
    if (!en) return int'(h);
    q   = int'(ph[31:30]);
    idx = int'(ph[29:22]);
    mag = (q == 0 || q == 2) ? lutRef(idx) : lutRef(255 - idx);
    s   = (q >= 2) ? -mag : mag;
    a   = floorDiv(s * mi, 65536);
    c   = h + floorDiv(a * h, 32768);
    if (c < 0) c = 0;
    if (c > pm) c = pm;
    return int'(c);
  endfunction

  // Advances the model across the edge that will sample the current inputs.
  task automatic modelEdge();
    pend_t it;
    expValid = 1'b0;
    if (!RstN) begin
      mPhase = '0;
      pend.delete();
      expCompare = 0;
      return;
    end
    foreach (pend[i]) pend[i].left--;
    if (pend.size() > 0 && pend[0].left == 0) begin
      it = pend.pop_front();
      expCompare = refCompare(it.en, it.ph, it.mi, int'(PWMMaxCount));
      expValid = 1'b1;
    end
    if (UpdateStrobe) begin
      it.en   = Enable;
      it.ph   = mPhase;
      it.mi   = int'(ModIndex);
      it.left = 3;
      pend.push_back(it);
      mPhase = Enable ? (mPhase + FreqWord) : 32'd0;
    end
  endtask

  task automatic cycle(input bit r, input bit s, input bit e, input logic [31:0] fw,
                       input logic [15:0] mi, input logic [15:0] pm);
    RstN         = r;
    UpdateStrobe = s;
    Enable       = e;
    FreqWord     = fw;
    ModIndex     = mi;
    PWMMaxCount  = pm;
    modelEdge();
    drvEdge++;
    @(negedge MClk);
  endtask

  task automatic checkEq(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkSeen(input string name);
    checkEq({name, "_count"}, seen.size(), expList.size());
    for (int i = 0; i < expList.size() && i < seen.size(); i++) begin
      checkEq($sformatf("%s_%0d", name, i), seen[i], expList[i]);
    end
  endtask

  // Per-cycle comparison against the model, sampled just after the edge.
  always @(posedge MClk) begin
    edgeNo++;
    #1;
    tests++;
    if (CompareValid !== expValid) begin
      fails++;
      $display("FAIL valid @edge %0d: got %0b, expected %0b", edgeNo, CompareValid, expValid);
    end
    tests++;
    if (Compare !== 16'(expCompare)) begin
      fails++;
      $display("FAIL compare @edge %0d: got %0d, expected %0d", edgeNo, Compare, expCompare);
    end
    if (CompareValid) begin
      seen.push_back(int'(Compare));
      seenEdges.push_back(edgeNo);
      if (firstValidEdge < 0) firstValidEdge = edgeNo;
    end
  end

  initial begin
    int strobeEdge;
    bit r;
    bit s;
    bit en;
    logic [31:0] fw;
    logic [15:0] mi;
    logic [15:0] pm;

    tests = 0;
    fails = 0;
    drvEdge = 0;
    edgeNo = 0;
    firstValidEdge = -1;
    mPhase = '0;
    expCompare = 0;
    expValid = 1'b0;

    // Model anchors computed by hand.
    checkEq("lut0", lutRef(0), 101);
    checkEq("lut255", lutRef(255), 32767);
    checkEq("ref_q0", refCompare(1'b1, 32'h0000_0000, 16'hFFFF, 2000), 1003);
    checkEq("ref_q1", refCompare(1'b1, 32'h4000_0000, 16'hFFFF, 2000), 1999);
    checkEq("ref_q2", refCompare(1'b1, 32'h8000_0000, 16'hFFFF, 2000), 996);
    checkEq("ref_q3", refCompare(1'b1, 32'hC000_0000, 16'hFFFF, 2000), 0);
    checkEq("ref_dis", refCompare(1'b0, 32'h4000_0000, 16'hFFFF, 2000), 1000);

    // Reset held while strobing.
    repeat (4) cycle(1'b0, 1'b1, 1'b1, 32'h4000_0000, 16'hFFFF, 16'd2000);
    checkEq("rst_compare", int'(Compare), 0);
    checkEq("rst_valid", int'(CompareValid), 0);
    checkEq("rst_no_pulse", seen.size(), 0);

    // First strobe after release.
    firstValidEdge = -1;
    seen.delete();
    cycle(1'b1, 1'b1, 1'b1, 32'h0, 16'h0, 16'd2000);
    strobeEdge = drvEdge;
    repeat (6) cycle(1'b1, 1'b0, 1'b1, 32'h0, 16'h0, 16'd2000);
    checkEq("latency", firstValidEdge - strobeEdge, 3);
    expList = '{1000};
    checkSeen("first");

    // Zero modulation index: midpoint every time.
    seen.delete();
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 1'b1, 1'b1, 32'h0, 16'h0, 16'd2000);
      repeat ($urandom_range(0, 2)) cycle(1'b1, 1'b0, 1'b1, 32'h0, 16'h0, 16'd2000);
    end
    repeat (5) cycle(1'b1, 1'b0, 1'b1, 32'h0, 16'h0, 16'd2000);
    expList = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
    checkSeen("mi0");

    // Back-to-back quarter-turn strobes at full amplitude.
    seen.delete();
    seenEdges.delete();
    repeat (8) cycle(1'b1, 1'b1, 1'b1, 32'h4000_0000, 16'hFFFF, 16'd2000);
    repeat (5) cycle(1'b1, 1'b0, 1'b1, 32'h4000_0000, 16'hFFFF, 16'd2000);
    expList = '{1003, 1999, 996, 0, 1003, 1999, 996, 0};
    checkSeen("b2b");
    if (seenEdges.size() == 8) checkEq("b2b_span", seenEdges[7] - seenEdges[0], 7);
    else checkEq("b2b_edges", seenEdges.size(), 8);

    // FreqWord change without a strobe has no effect.
    seen.delete();
    repeat (3) cycle(1'b1, 1'b0, 1'b1, 32'h0, 16'hFFFF, 16'd2000);
    repeat (3) cycle(1'b1, 1'b1, 1'b1, 32'h0, 16'hFFFF, 16'd2000);
    repeat (5) cycle(1'b1, 1'b0, 1'b1, 32'h0, 16'hFFFF, 16'd2000);
    expList = '{1003, 1003, 1003};
    checkSeen("fw0");

    // Disabled strobes give midpoint and restart the phase.
    seen.delete();
    cycle(1'b1, 1'b1, 1'b1, 32'h4000_0000, 16'hFFFF, 16'd2000);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'h4000_0000, 16'hFFFF, 16'd2000);
    repeat (4) cycle(1'b1, 1'b1, 1'b1, 32'h4000_0000, 16'hFFFF, 16'd2000);
    repeat (5) cycle(1'b1, 1'b0, 1'b1, 32'h4000_0000, 16'hFFFF, 16'd2000);
    expList = '{1003, 1000, 1000, 1000, 1003, 1999, 996, 0};
    checkSeen("enable");

    // One-cycle reset with two samples in flight.
    seen.delete();
    cycle(1'b1, 1'b1, 1'b1, 32'h0, 16'h0, 16'd2000);
    repeat (5) cycle(1'b1, 1'b0, 1'b1, 32'h0, 16'h0, 16'd2000);
    checkEq("pre_rst_compare", int'(Compare), 1000);
    repeat (2) cycle(1'b1, 1'b1, 1'b1, 32'h4000_0000, 16'hFFFF, 16'd2000);
    cycle(1'b0, 1'b0, 1'b1, 32'h4000_0000, 16'hFFFF, 16'd2000);
    checkEq("inflight_rst_compare", int'(Compare), 0);
    repeat (6) cycle(1'b1, 1'b0, 1'b1, 32'h4000_0000, 16'hFFFF, 16'd2000);
    expList = '{1000};
    checkSeen("inflight");

    // Randomized traffic against the model.
    en = 1'b1;
    pm = 16'd2000;
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 199) != 0);
      s = ($urandom_range(0, 1) == 1);
      if (s) en = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 3))
        0:       fw = $urandom();
        1:       fw = 32'($urandom_range(0, 1023)) << 22;
        2:       fw = 32'h4000_0000;
        default: fw = 32'($urandom_range(0, 65535));
      endcase
      mi = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom());
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 4))
          0:       pm = 16'd0;
          1:       pm = 16'd1;
          2:       pm = 16'hFFFF;
          3:       pm = 16'd2000;
          default: pm = 16'($urandom());
        endcase
      end
      cycle(r, s, en, fw, mi, pm);
    end
    repeat (5) cycle(1'b1, 1'b0, en, 32'h0, 16'h0, pm);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mod_ref_gen.md
# mod_ref_gen

Sinusoidal modulation-reference generator that produces the 16-bit `Compare` word consumed by each PWM level stage. It holds a phase accumulator advanced once per carrier-period strobe, uses a quarter-wave sine LUT, scales the sine by a modulation index, and centres the result in the range 0..`PWMMaxCount`. It sits directly upstream of the level stages; one instance feeds all levels of a phase leg.

## Interface
- `PHASE_W`, 32: phase accumulator width.
- `LUT_AW`, 8: quarter-wave LUT address width (256 entries).
- `MClk`  in  1  system clock; all logic rising-edge.
- `RstN`  in  1  reset; one clock, synchronous, active-low.
- `Enable`  in  1  1 = run; 0 = phase forced to 0, output forced to midpoint.
- `UpdateStrobe`  in  1  one-cycle pulse per carrier period (sample request).
- `FreqWord`  in  32  phase increment per strobe; sampled only on strobe.
- `ModIndex`  in  16  unsigned Q0.16 amplitude, where 0xFFFF ≈ 1.0; sampled only on strobe.
- `PWMMaxCount`  in  16  carrier full-scale; same value as given to the level stages.
- `Compare`  out  16  reference for the level stages; registered.
- `CompareValid`  out  1  one-cycle pulse when `Compare` updates.

## Operation
- Stage 0, on `UpdateStrobe`:
  - If `Enable`=1: `Phase <= Phase + FreqWord`, with wrap-around mod 2^32.
  - If `Enable`=0: `Phase <= 0`.
  - The pre-increment `Phase`, `ModIndex` and `Enable` are captured into the pipeline, so the first sample after enable uses phase 0.
- Stage 1, LUT lookup:
  - quadrant = `Phase[31:30]`; idx = `Phase[29:22]`.
  - LUT[i] = round(32767·sin((i+0.5)·π/512)), unsigned 15-bit; LUT[0]=101, LUT[255]=32767.
  - Q0: +LUT[idx]. Q1: +LUT[~idx]. Q2: −LUT[idx]. Q3: −LUT[~idx].
  - Result is signed 16-bit `s`.
- Stage 2, amplitude scaling:
  - `a = (s × {1'b0,ModIndex}) >>> 16`.
  - Multiply is 33-bit signed; the shift is arithmetic (floor). Result is signed 16-bit.
- Stage 3, offset into carrier range:
  - `H = PWMMaxCount >> 1`.
  - `c = H + ((a × H) >>> 15)`.
  - Clamp `c` to [0, `PWMMaxCount`] and register it into `Compare`.
  - If the captured `Enable` was 0, `Compare <= H`.
- Fully pipelined: a strobe is accepted every cycle, including back-to-back strobes. There is no backpressure and no dropped strobe.
- `FreqWord`/`ModIndex` changes without a strobe have no effect on output.
- `PWMMaxCount` is read live at stage 3.

## Timing
- Strobe at cycle N gives `Compare` and `CompareValid` valid at the end of cycle N+3, so latency is 3.
- `CompareValid` is high exactly one cycle per accepted strobe. `Compare` holds its value between pulses.
- Reset (`RstN`=0 at an edge):
  - `Phase`=0, all pipeline valid bits=0, `Compare`=0, `CompareValid`=0.
  - In-flight samples are discarded; no `CompareValid` is produced for strobes issued before or during reset.
- Strobe in the same cycle that `RstN`=0: the strobe is ignored.
- `Enable` falling mid-pipeline: samples already captured complete with their own `Enable` value.
- Output bound: for every input, 0 ≤ `Compare` ≤ `PWMMaxCount`. The clamp is a safety net and is never active in normal arithmetic.

## Structure
- A shared PWM package holds:
  - width constants `PHASE_W`, `LUT_AW`, `CMP_W`=16;
  - the quadrant enum type (`Q0..Q3`);
  - the typedef for the signed sample.
- Sub-module `sine_quarter_lut`: synchronous-read ROM, 256×15. The address is registered inside it and provides the stage-1 register. Contents come from a generated initial block or `$readmemh`.
- Multiplies are inferred `*` operators. Do not use division anywhere; the halving is a shift.

## Test plan
- Reset: hold `RstN`=0 while strobing → `Compare`=0 and `CompareValid`=0 throughout. First strobe after release gives `CompareValid` 3 cycles later.
- `PWMMaxCount`=2000, `ModIndex`=0, `Enable`=1, 8 strobes → every `Compare`=1000, one valid pulse per strobe.
- `PWMMaxCount`=2000, `ModIndex`=0xFFFF, `FreqWord`=0x40000000, back-to-back strobes → `Compare` sequence 1003, 1999, 996, 0, repeating; pulses on consecutive cycles.
- Change `FreqWord` from 0x40000000 to 0 without a strobe → next output unchanged from the prediction. After the strobe that samples 0, `Compare` stays constant.
- `Enable`=0 for 3 strobes, then `Enable`=1 with the sequence above:
  - the first 3 outputs are 1000;
  - the next output is 1003, because phase restarts at 0.
- Assert `RstN`=0 for one cycle with 2 samples in flight → neither produces `CompareValid`, and `Compare`=0 after the edge.
